// File: rtl/display_arbiter_if.sv
// Display arbiter bus: requester side (master) and arbiter side (slave).
interface display_arbiter_if;
   logic [2:0]  req;
   logic [2:0]  blink;
   logic [15:0] data0;
   logic [15:0] data1;
   logic [15:0] data2;
   logic [2:0]  grant;
   logic        disp_en;
   logic [3:0]  content_0;
   logic [3:0]  content_1;
   logic [3:0]  content_2;
   logic [3:0]  content_3;

   modport master (
      output req, blink, data0, data1, data2,
      input  grant, disp_en, content_0, content_1, content_2, content_3
   );

   modport slave (
      input  req, blink, data0, data1, data2,
      output grant, disp_en, content_0, content_1, content_2, content_3
   );
endinterface

// File: rtl/display_arbiter.sv
// Shares one 4-digit 7-seg scanner between three requesters (2 highest priority).
// An owner keeps the display for at least MIN_TICKS edges, then the arbiter
// re-checks requests every edge. Digits are registered from the owner's data,
// and disp_en is gated by an optional blink phase.
module display_arbiter #(
   parameter int MIN_TICKS  = 500,
   parameter int BLINK_HALF = 125
) (
   input logic              clk_500Hz,
   input logic              rst_n,
   display_arbiter_if.slave bus
);
   localparam int MW = (MIN_TICKS  > 1) ? $clog2(MIN_TICKS)  : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [MW-1:0] MIN_LOAD   = MW'(MIN_TICKS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   typedef enum logic {S_IDLE, S_OWN} state_t;

   state_t          state_q, state_d;
   logic [2:0]      grant_q, grant_d;
   logic [MW-1:0]   min_cnt_q, min_cnt_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic            phase_q, phase_d;
   logic            disp_en_q, disp_en_d;
   logic [15:0]     content_q, content_d;
   logic [2:0]      hi_req;
   logic            load;
   logic [15:0]     sel_data;

   // Next-state, owner selection, counters, and output values.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      min_cnt_d   = min_cnt_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      load        = 1'b0;

      // Fixed priority: the highest set index wins.
      if (bus.req[2])      hi_req = 3'b100;
      else if (bus.req[1]) hi_req = 3'b010;
      else if (bus.req[0]) hi_req = 3'b001;
      else                 hi_req = 3'b000;

      case (state_q)
         S_IDLE: begin
            grant_d = 3'b000;
            if (bus.req != 3'b000) begin
               state_d = S_OWN;
               grant_d = hi_req;
               load    = 1'b1;
            end
         end
         S_OWN: begin
            if (min_cnt_q != '0) begin
               // Ownership window still running: no preemption.
               min_cnt_d = min_cnt_q - 1'b1;
            end else if (bus.req == 3'b000) begin
               state_d = S_IDLE;
               grant_d = 3'b000;
            end else if (hi_req != grant_q) begin
               // Hand over directly, without an idle cycle.
               grant_d = hi_req;
               load    = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 3'b000;
         end
      endcase

      if (load) begin
         min_cnt_d   = MIN_LOAD;
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (state_d == S_OWN) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end else begin
         min_cnt_d   = '0;
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end

      // Content follows the next owner; all-zero grant yields blank digits.
      unique case (1'b1)
         grant_d[2]: sel_data = bus.data2;
         grant_d[1]: sel_data = bus.data1;
         grant_d[0]: sel_data = bus.data0;
         default:    sel_data = 16'h0000;
      endcase
      content_d = sel_data;

      disp_en_d = (state_d == S_OWN) & (~(|(grant_d & bus.blink)) | phase_d);
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk_500Hz or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         grant_q     <= 3'b000;
         min_cnt_q   <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
         disp_en_q   <= 1'b0;
         content_q   <= 16'h0000;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         min_cnt_q   <= min_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         disp_en_q   <= disp_en_d;
         content_q   <= content_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.disp_en   = disp_en_q;
   assign bus.content_0 = content_q[3:0];
   assign bus.content_1 = content_q[7:4];
   assign bus.content_2 = content_q[11:8];
   assign bus.content_3 = content_q[15:12];
endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with MIN_TICKS=4, BLINK_HALF=2.
module tb_display_arbiter;
   logic clk_500Hz = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   display_arbiter_if bus();

   display_arbiter #(.MIN_TICKS(4), .BLINK_HALF(2)) dut (
      .clk_500Hz (clk_500Hz),
      .rst_n     (rst_n),
      .bus       (bus)
   );

   always #5 clk_500Hz = ~clk_500Hz;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk_500Hz);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      $display("check %s obs=%h exp=%h", tag, obs, exp);
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] content();
      return {bus.content_3, bus.content_2, bus.content_1, bus.content_0};
   endfunction

   initial begin
      rst_n     = 1'b0;
      bus.req   = 3'b000;
      bus.blink = 3'b000;
      bus.data0 = 16'h1234;
      bus.data1 = 16'h5678;
      bus.data2 = 16'h9ABC;
      #1;
      chk("rst_grant", 16'(bus.grant), 16'h0);
      chk("rst_en", 16'(bus.disp_en), 16'h0);
      chk("rst_content", content(), 16'h0);
      step(2);
      rst_n = 1'b1;
      step(1);
      chk("idle_grant", 16'(bus.grant), 16'h0);

      // 1: grant after one edge, then asynchronous reset mid-ownership
      bus.req = 3'b001;
      step(1);
      chk("t1_grant", 16'(bus.grant), 16'h1);
      chk("t1_en", 16'(bus.disp_en), 16'h1);
      chk("t1_content", content(), 16'h1234);
      step(1);
      rst_n = 1'b0;
      #1;
      chk("t1_arst_grant", 16'(bus.grant), 16'h0);
      chk("t1_arst_en", 16'(bus.disp_en), 16'h0);
      chk("t1_arst_content", content(), 16'h0);
      bus.req = 3'b000;
      step(1);
      rst_n = 1'b1;
      step(1);
      chk("t1_idle", 16'(bus.grant), 16'h0);

      // 2: no preemption inside window, direct switch at re-arbitration
      bus.req = 3'b001;
      step(1);
      chk("t2_grant0", 16'(bus.grant), 16'h1);
      bus.req = 3'b101;
      step(3);
      chk("t2_hold", 16'(bus.grant), 16'h1);
      chk("t2_hold_content", content(), 16'h1234);
      step(1);
      chk("t2_switch", 16'(bus.grant), 16'h4);
      chk("t2_switch_en", 16'(bus.disp_en), 16'h1);
      chk("t2_switch_content", content(), 16'h9ABC);
      bus.req = 3'b000;
      step(4);
      chk("t2_idle", 16'(bus.grant), 16'h0);

      // 3: one-cycle pulse holds exactly MIN_TICKS cycles
      bus.req = 3'b010;
      step(1);
      chk("t3_grant", 16'(bus.grant), 16'h2);
      chk("t3_content", content(), 16'h5678);
      bus.req = 3'b000;
      step(3);
      chk("t3_last", 16'(bus.grant), 16'h2);
      step(1);
      chk("t3_idle_grant", 16'(bus.grant), 16'h0);
      chk("t3_idle_en", 16'(bus.disp_en), 16'h0);
      chk("t3_idle_content", content(), 16'h0);

      // 4: simultaneous requests, live data tracking
      bus.req = 3'b111;
      step(1);
      chk("t4_grant", 16'(bus.grant), 16'h4);
      bus.data2 = 16'hFEDC;
      chk("t4_content_old", content(), 16'h9ABC);
      step(1);
      chk("t4_content_new", content(), 16'hFEDC);
      bus.req = 3'b000;
      step(3);
      chk("t4_idle", 16'(bus.grant), 16'h0);

      // 5: blink pattern 1,1,0,0,1,1,0 then blink drop re-enables
      bus.req   = 3'b100;
      bus.blink = 3'b100;
      step(1);
      chk("t5_en0", 16'(bus.disp_en), 16'h1);
      step(1);
      chk("t5_en1", 16'(bus.disp_en), 16'h1);
      step(1);
      chk("t5_en2", 16'(bus.disp_en), 16'h0);
      step(1);
      chk("t5_en3", 16'(bus.disp_en), 16'h0);
      step(1);
      chk("t5_en4", 16'(bus.disp_en), 16'h1);
      chk("t5_grant_kept", 16'(bus.grant), 16'h4);
      step(1);
      chk("t5_en5", 16'(bus.disp_en), 16'h1);
      step(1);
      chk("t5_en6", 16'(bus.disp_en), 16'h0);
      bus.blink = 3'b000;
      step(1);
      chk("t5_unblink", 16'(bus.disp_en), 16'h1);
      bus.req = 3'b000;
      step(1);
      chk("t5_idle", 16'(bus.grant), 16'h0);

      // 6: drop at re-arbitration edge, then fresh grant with reloaded counters
      bus.req = 3'b010;
      step(1);
      chk("t6_grant1", 16'(bus.grant), 16'h2);
      step(3);
      chk("t6_hold", 16'(bus.grant), 16'h2);
      bus.req = 3'b000;
      step(1);
      chk("t6_idle_grant", 16'(bus.grant), 16'h0);
      chk("t6_idle_en", 16'(bus.disp_en), 16'h0);
      bus.req = 3'b001;
      step(1);
      chk("t6_regrant", 16'(bus.grant), 16'h1);
      chk("t6_regrant_content", content(), 16'h1234);
      bus.req   = 3'b000;
      bus.blink = 3'b001;
      step(1);
      chk("t6_phase_a", 16'(bus.disp_en), 16'h1);
      step(1);
      chk("t6_phase_b", 16'(bus.disp_en), 16'h0);
      step(1);
      chk("t6_min_hold", 16'(bus.grant), 16'h1);
      step(1);
      chk("t6_min_end", 16'(bus.grant), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
